// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor: widths, opcodes and the fetch FSM encoding.
package proc_pkg;

    localparam int ADDR_W   = 4;
    localparam int INSTR_W  = 8;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_HOLD,
        ST_HALTED
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: OPCODE_W] == OP_HALT;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction memory req/ack on one side, valid/ready toward the control unit.
interface instr_fetch_if import proc_pkg::*; ;

    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_ack;
    logic [INSTR_W-1:0]    mem_rdata;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [OPCODE_W-1:0]   opcode;
    logic [OPCODE_W-1:0]   operand;

    modport master (
        output mem_req, mem_addr, instr_valid, opcode, operand,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, opcode, operand,
        output mem_ack, mem_rdata, instr_ready
    );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the pc, fetches words over req/ack and presents opcode/operand
// over valid/ready; handles HALT internally and redirects the pc on branch requests.
module instr_fetch import proc_pkg::*; (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                branch_en,
    input  logic [ADDR_W-1:0]   branch_target,
    instr_fetch_if.master       bus,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted
);

    fetch_state_e         state_q, state_d;
    logic [ADDR_W-1:0]    pc_q, pc_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;
    logic                 discard_q, discard_d;
    logic                 gap_q, gap_d;
    logic                 req;
    logic                 ack;

    // gap_q forces one idle cycle on mem_req after every ack, even when staying in REQ.
    assign req = (state_q == ST_REQ) && !gap_q;
    assign ack = req && bus.mem_ack;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            addr_q    <= '0;
            ir_q      <= '0;
            discard_q <= 1'b0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            ir_q      <= ir_d;
            discard_q <= discard_d;
            gap_q     <= gap_d;
        end
    end

    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        ir_d      = ir_q;
        discard_d = discard_q;
        gap_d     = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start)     state_d = ST_REQ;
                if (branch_en) pc_d    = branch_target;
            end
            ST_REQ: begin
                if (ack) begin
                    gap_d     = 1'b1;
                    discard_d = 1'b0;
                    if (branch_en) begin
                        pc_d = branch_target;
                    end else if (!discard_q) begin
                        ir_d    = bus.mem_rdata;
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = is_halt(bus.mem_rdata) ? ST_HALTED : ST_HOLD;
                    end
                end else if (branch_en) begin
                    pc_d = branch_target;
                    // Outstanding request keeps its original address until the ack arrives.
                    if (req && !discard_q) begin
                        discard_d = 1'b1;
                        addr_d    = pc_q;
                    end
                end
            end
            ST_HOLD: begin
                if (branch_en) begin
                    pc_d    = branch_target;
                    state_d = ST_REQ;
                end else if (bus.instr_ready) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_req     = req;
    assign bus.mem_addr    = discard_q ? addr_q : pc_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.opcode      = ir_q[INSTR_W-1 -: OPCODE_W];
    assign bus.operand     = ir_q[OPCODE_W-1:0];
    assign pc              = pc_q;
    assign halted          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a registered instruction memory model, a transfer monitor,
// a vector table for the basic fetch/halt run and hand-written branch/wrap/reset sequences.
module tb_instr_fetch;
    import proc_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              branch_en = 1'b0;
    logic [ADDR_W-1:0] branch_target = '0;
    logic [ADDR_W-1:0] pc;
    logic              halted;

    instr_fetch_if bus();

    instr_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .bus           (bus),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] imem [16];
    int         mem_wait = 0;

    int         xfer_count = 0;
    logic [7:0] last_xfer = '0;

    typedef struct {
        logic [7:0] word;
        logic [3:0] exp_op;
        logic [3:0] exp_operand;
        logic [3:0] exp_pc;
        logic       exp_halt;
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!bus.instr_valid && n < budget) begin
            tick();
            n++;
        end
        check({name, "_valid_seen"}, bus.instr_valid, 1);
    endtask

    // Registered memory: acks one cycle (plus mem_wait) after it first sees mem_req.
    initial begin
        int   wcnt = 0;
        logic req_prev = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                bus.mem_ack = 1'b0;
                wcnt        = 0;
                req_prev    = 1'b0;
            end else begin
                if (bus.mem_ack) begin
                    bus.mem_ack = 1'b0;
                    wcnt        = 0;
                end else if (req_prev && bus.mem_req) begin
                    if (wcnt >= mem_wait) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = imem[bus.mem_addr];
                    end else begin
                        wcnt++;
                    end
                end
                req_prev = bus.mem_req;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.instr_valid && bus.instr_ready) begin
                xfer_count++;
                last_xfer = {bus.opcode, bus.operand};
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   xb;
        int   n;
        logic saw_valid;
        logic saw_gap;
        logic saw_req;

        vecs[0] = '{word: 8'h31, exp_op: 4'h3, exp_operand: 4'h1, exp_pc: 4'h1, exp_halt: 1'b0};
        vecs[1] = '{word: 8'h25, exp_op: 4'h2, exp_operand: 4'h5, exp_pc: 4'h2, exp_halt: 1'b0};
        vecs[2] = '{word: 8'hF0, exp_op: 4'h0, exp_operand: 4'h0, exp_pc: 4'h3, exp_halt: 1'b1};
        for (int i = 0; i < 16; i++) imem[i] = 8'h00;
        for (int i = 0; i < 3; i++) imem[i] = vecs[i].word;
        bus.instr_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_opcode", bus.opcode, 0);
        check("rst_operand", bus.operand, 0);
        check("rst_pc", pc, 0);
        check("rst_halted", halted, 0);
        rst_n = 1'b1;
        tick();

        // Basic fetch run ending in HALT
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_req", bus.mem_req, 1);
        check("start_addr", bus.mem_addr, 0);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!(bus.instr_valid || halted) && n < 20) begin
                tick();
                n++;
            end
            if (vecs[i].exp_halt) begin
                check($sformatf("v%0d_halted", i), halted, 1);
                check($sformatf("v%0d_valid", i), bus.instr_valid, 0);
            end else begin
                check($sformatf("v%0d_valid", i), bus.instr_valid, 1);
                check($sformatf("v%0d_opcode", i), bus.opcode, vecs[i].exp_op);
                check($sformatf("v%0d_operand", i), bus.operand, vecs[i].exp_operand);
                tick();
            end
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
        end
        saw_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_req |= bus.mem_req;
        end
        check("halted_no_req", saw_req, 0);
        check("halt_xfers", xfer_count, 2);

        // Branch while halted, then backpressure in HOLD
        branch_en     = 1'b1;
        branch_target = 4'h0;
        tick();
        branch_en = 1'b0;
        check("halt_branch_state", halted, 1);
        check("halt_branch_pc", pc, 0);
        bus.instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_halted", halted, 0);
        wait_valid("bp", 20);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_stable%0d", i),
                  {bus.instr_valid, bus.opcode, bus.mem_req, pc}, {1'b1, 4'h3, 1'b0, 4'h1});
            tick();
        end
        mem_wait = 3;
        bus.instr_ready = 1'b1;
        tick();
        check("bp_xfers", xfer_count, 3);
        check("xfer_req", bus.mem_req, 1);
        check("xfer_addr", bus.mem_addr, 1);

        // Branch in REQ with delayed ack: old data discarded
        imem[4'hA]    = 8'h4C;
        branch_en     = 1'b1;
        branch_target = 4'hA;
        tick();
        branch_en = 1'b0;
        check("brq_req_held", bus.mem_req, 1);
        check("brq_addr_old", bus.mem_addr, 1);
        check("brq_pc", pc, 4'hA);
        n = 0;
        saw_valid = 1'b0;
        saw_gap   = 1'b0;
        while (!(bus.mem_req && bus.mem_addr == 4'hA) && n < 20) begin
            tick();
            n++;
            saw_valid |= bus.instr_valid;
            saw_gap   |= !bus.mem_req;
        end
        mem_wait = 0;
        check("brq_new_req", {bus.mem_req, bus.mem_addr}, {1'b1, 4'hA});
        check("brq_no_present", saw_valid, 0);
        check("brq_gap", saw_gap, 1);
        check("brq_pc_not_inc", pc, 4'hA);
        wait_valid("brq", 20);
        check("brq_opcode", bus.opcode, 4'h4);
        check("brq_operand", bus.operand, 4'hC);
        check("brq_pc_next", pc, 4'hB);

        // Branch in HOLD together with a transfer
        xb            = xfer_count;
        branch_en     = 1'b1;
        branch_target = 4'h5;
        tick();
        branch_en = 1'b0;
        check("bhold_xfer_once", xfer_count, xb + 1);
        check("bhold_xfer_data", last_xfer, 8'h4C);
        check("bhold_valid", bus.instr_valid, 0);
        check("bhold_pc", pc, 4'h5);
        check("bhold_req", {bus.mem_req, bus.mem_addr}, {1'b1, 4'h5});

        // Branch in REQ on the ack cycle: word dropped, redirect to 4'hF
        imem[4'h5] = 8'h77;
        imem[4'hF] = 8'h32;
        n = 0;
        while (!bus.mem_ack && n < 20) begin
            tick();
            n++;
        end
        check("back_ack_seen", bus.mem_ack, 1);
        branch_en     = 1'b1;
        branch_target = 4'hF;
        tick();
        branch_en = 1'b0;
        check("back_pc", pc, 4'hF);
        check("back_req_gap", bus.mem_req, 0);
        check("back_valid", bus.instr_valid, 0);
        tick();
        check("back_req", {bus.mem_req, bus.mem_addr}, {1'b1, 4'hF});

        // pc wrap from 4'hF
        wait_valid("wrap", 20);
        check("wrap_opcode", bus.opcode, OP_ADD);
        check("wrap_operand", bus.operand, 4'h2);
        check("wrap_pc", pc, 4'h0);
        tick();
        check("wrap_req", {bus.mem_req, bus.mem_addr}, {1'b1, 4'h0});

        // Reset while a request is outstanding
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_mem_req", bus.mem_req, 0);
        check("mrst_mem_addr", bus.mem_addr, 0);
        check("mrst_valid", bus.instr_valid, 0);
        check("mrst_opcode", bus.opcode, 0);
        check("mrst_operand", bus.operand, 0);
        check("mrst_pc", pc, 0);
        check("mrst_halted", halted, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        saw_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_req |= bus.mem_req;
        end
        check("mrst_idle_no_req", saw_req, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mrst_restart", {bus.mem_req, bus.mem_addr}, {1'b1, 4'h0});
        wait_valid("mrst", 20);
        check("mrst_opcode_after", bus.opcode, 4'h3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
